alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 38 +++
 rtl/alu_mc_core.sv | 124 ++++++++++++
 rtl/alu_mc.sv | 161 ++++++++++++++++
 tb/tb_alu_mc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Holds the op codes, the status flag bit positions and the FSM state encoding.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_TRA = 4'd2,
        OP_TRB = 4'd3,
        OP_NEG = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_EOR = 4'd7,
        OP_ROR = 4'd8,
        OP_ROL = 4'd9,
        OP_ADC = 4'd10,
        OP_SBC = 4'd11,
        OP_MUL = 4'd12,
        OP_LSR = 4'd13,
        OP_ASR = 4'd14,
        OP_RSV = 4'd15
    } op_e;

    // Bit positions of the flags inside the 8-bit status register.
    // Bits 7:5 are general-purpose and only change through an explicit status write.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_S = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_core.sv
// Combinational datapath for all single-cycle operations (op codes 0-11).
// Flags follow AVR rules with bit W-1 acting as the sign bit; op codes that
// are not handled here return zero and pass the incoming flags through.
module alu_core
    import alu_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    input  logic [4:0]   flags_in,
    output logic [W-1:0] res,
    output logic [4:0]   flags_out
);

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    // Signed overflow of x + y giving z: both operands agree in sign, result does not.
    function automatic logic add_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] z);
        return (x[W-1] & y[W-1] & ~z[W-1]) | (~x[W-1] & ~y[W-1] & z[W-1]);
    endfunction

    // Signed overflow of x - y giving z: operands differ in sign and z takes the sign of y.
    function automatic logic sub_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] z);
        return (x[W-1] & ~y[W-1] & ~z[W-1]) | (~x[W-1] & y[W-1] & z[W-1]);
    endfunction

    logic [W:0] ext;
    logic       cin;
    logic       c_new;
    logic       v_new;
    logic       keep_c;
    logic       upd;

    // Compute the result and the new flag set; N, Z and S are common to every handled op.
    always_comb begin
        cin       = flags_in[FLAG_C];
        ext       = '0;
        res       = '0;
        c_new     = 1'b0;
        v_new     = 1'b0;
        keep_c    = 1'b0;
        upd       = 1'b1;
        flags_out = flags_in;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                res   = ext[W-1:0];
                c_new = ext[W];
                v_new = add_ovf(a, b, res);
            end
            OP_ADC: begin
                ext   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                res   = ext[W-1:0];
                c_new = ext[W];
                v_new = add_ovf(a, b, res);
            end
            OP_SUB: begin
                ext   = {1'b0, a} - {1'b0, b};
                res   = ext[W-1:0];
                c_new = ext[W];
                v_new = sub_ovf(a, b, res);
            end
            OP_SBC: begin
                ext   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                res   = ext[W-1:0];
                c_new = ext[W];
                v_new = sub_ovf(a, b, res);
            end
            OP_NEG: begin
                res   = {W{1'b0}} - a;
                c_new = (res != '0);
                v_new = (res == MIN_NEG);
            end
            OP_TRA: begin
                res    = a;
                keep_c = 1'b1;
            end
            OP_TRB: begin
                res    = b;
                keep_c = 1'b1;
            end
            OP_AND: begin
                res    = a & b;
                keep_c = 1'b1;
            end
            OP_OR: begin
                res    = a | b;
                keep_c = 1'b1;
            end
            OP_EOR: begin
                res    = a ^ b;
                keep_c = 1'b1;
            end
            OP_ROR: begin
                res   = {cin, a[W-1:1]};
                c_new = a[0];
                v_new = res[W-1] ^ a[0];
            end
            OP_ROL: begin
                res   = {a[W-2:0], cin};
                c_new = a[W-1];
                v_new = res[W-1] ^ a[W-1];
            end
            default: begin
                res = '0;
                upd = 1'b0;
            end
        endcase
        if (upd) begin
            flags_out[FLAG_N] = res[W-1];
            flags_out[FLAG_Z] = (res == '0);
            flags_out[FLAG_V] = v_new;
            flags_out[FLAG_S] = res[W-1] ^ v_new;
            if (!keep_c) begin
                flags_out[FLAG_C] = c_new;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: IDLE/RUN/DONE sequencer around the combinational core,
// with an iterative shift-add multiplier and a one-bit-per-cycle shifter.
// Results and flags only become visible on entry to DONE or via a status write.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    input  logic         start,
    input  logic         st_wr,
    input  logic [7:0]   st_in,
    output logic [W-1:0] r,
    output logic [W-1:0] r_hi,
    output logic [7:0]   st,
    output logic         busy,
    output logic         done
);

    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   r_hi_q, r_hi_d;
    logic [7:0]     st_q, st_d;

    logic [W-1:0]   core_res;
    logic [4:0]     core_flags;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_next;
    logic [W-1:0]   sh_next;
    logic [SW-1:0]  sh_amt;

    alu_core #(.W(W)) u_core (
        .a        (a),
        .b        (b),
        .op       (op),
        .flags_in (st_q[4:0]),
        .res      (core_res),
        .flags_out(core_flags)
    );

    assign sh_amt = b[SW-1:0];
    assign r      = r_q;
    assign r_hi   = r_hi_q;
    assign st     = st_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

    // Next-state logic: accept new work outside RUN, iterate MUL/shift in RUN,
    // and publish results together with flags on the edge into DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        r_d       = r_q;
        r_hi_d    = r_hi_q;
        st_d      = st_wr ? st_in : st_q;
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        prod_next = {mul_sum, prod_q[W-1:1]};
        sh_next   = {(op_q == OP_ASR) ? prod_q[W-1] : 1'b0, prod_q[W-1:1]};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d = op;
                    case (op)
                        OP_MUL: begin
                            mcand_d = a;
                            prod_d  = {{W{1'b0}}, b};
                            cnt_d   = CW'(W);
                            state_d = ST_RUN;
                        end
                        OP_LSR, OP_ASR: begin
                            if (sh_amt == '0) begin
                                r_d       = a;
                                r_hi_d    = '0;
                                st_d[4:0] = st_q[4:0];
                                state_d   = ST_DONE;
                            end else begin
                                prod_d  = {{W{1'b0}}, a};
                                cnt_d   = {1'b0, sh_amt};
                                state_d = ST_RUN;
                            end
                        end
                        default: begin
                            r_d       = core_res;
                            r_hi_d    = '0;
                            st_d[4:0] = core_flags;
                            state_d   = ST_DONE;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    prod_d = prod_next;
                    if (cnt_q == CW'(1)) begin
                        r_d            = prod_next[W-1:0];
                        r_hi_d         = prod_next[2*W-1:W];
                        st_d[4:0]      = st_q[4:0];
                        st_d[FLAG_C]   = prod_next[2*W-1];
                        st_d[FLAG_Z]   = (prod_next == '0);
                        state_d        = ST_DONE;
                    end
                end else begin
                    prod_d = {prod_q[2*W-1:W], sh_next};
                    if (cnt_q == CW'(1)) begin
                        r_d          = sh_next;
                        r_hi_d       = '0;
                        st_d[FLAG_C] = prod_q[0];
                        st_d[FLAG_Z] = (sh_next == '0);
                        st_d[FLAG_N] = sh_next[W-1];
                        st_d[FLAG_V] = sh_next[W-1] ^ prod_q[0];
                        st_d[FLAG_S] = prod_q[0];
                        state_d      = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any running op without a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            r_q     <= '0;
            r_hi_q  <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            r_q     <= r_d;
            r_hi_q  <= r_hi_d;
            st_q    <= st_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at W=8: a table of operations with
// hand-derived results, plus sequences for restart, overlap and reset abort.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         start, st_wr;
    logic [7:0]   st_in;
    logic [W-1:0] r, r_hi;
    logic [7:0]   st;
    logic         busy, done;

    alu_mc #(.W(W)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .op   (op),
        .start(start),
        .st_wr(st_wr),
        .st_in(st_in),
        .r    (r),
        .r_hi (r_hi),
        .st   (st),
        .busy (busy),
        .done (done)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [7:0]   st_pre;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_r_hi;
        logic [7:0]   exp_st;
        int           exp_lat;
        int           exp_busy;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] r_hi;
        logic [7:0]   st;
        int           lat;
        int           busy_cycles;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[21];
    int   checks = 0;
    int   errors = 0;
    int   lat_seen;
    int   busy_seen;
    bit   timed_out;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Wait for done with a cycle budget, optionally pulsing start mid-run and
    // checking that the visible result holds its old value while busy.
    task automatic waitDone(input string name, input int pulse_at, input bit check_hold,
                            input logic [W-1:0] hold_r);
        bit finished;
        finished  = 1'b0;
        lat_seen  = 0;
        busy_seen = 0;
        timed_out = 1'b0;
        while (!finished) begin
            @(negedge clk);
            lat_seen++;
            start = (lat_seen == pulse_at);
            if (start) begin
                op = OP_ADD;
                a  = 8'h01;
                b  = 8'h01;
            end
            if (busy) busy_seen++;
            if (check_hold && lat_seen == 5) begin
                check({name, " r held"}, r, hold_r);
                check({name, " r_hi held"}, r_hi, 0);
            end
            if (done) begin
                finished = 1'b1;
            end else if (lat_seen >= 200) begin
                timed_out = 1'b1;
                finished  = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, " scoreboard entry"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        if (timed_out) begin
            check({name, " done seen"}, done, 1);
            return;
        end
        check({name, " r"}, r, e.r);
        check({name, " r_hi"}, r_hi, e.r_hi);
        check({name, " st"}, st, e.st);
        check({name, " latency"}, lat_seen, e.lat);
        check({name, " busy cycles"}, busy_seen, e.busy_cycles);
    endtask

    task automatic applyStimulus(input vec_t v, input string name, input int pulse_at,
                                 input bit check_hold, input logic [W-1:0] hold_r);
        exp_t e;
        @(negedge clk);
        st_wr = 1'b1;
        st_in = v.st_pre;
        @(negedge clk);
        st_wr = 1'b0;
        check({name, " st_wr load"}, st, v.st_pre);
        e.r           = v.exp_r;
        e.r_hi        = v.exp_r_hi;
        e.st          = v.exp_st;
        e.lat         = v.exp_lat;
        e.busy_cycles = v.exp_busy;
        sb_q.push_back(e);
        op    = v.op;
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        waitDone(name, pulse_at, check_hold, hold_r);
        checkOutput(name);
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   pulses;
        vec_t v;

        //          op      a      b      st_pre  r      r_hi   st     lat busy
        vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h00, 8'h0C, 1, 0};
        vecs[1]  = '{OP_SUB, 8'h10, 8'h20, 8'h00, 8'hF0, 8'h00, 8'h15, 1, 0};
        vecs[2]  = '{OP_TRA, 8'h00, 8'h55, 8'h01, 8'h00, 8'h00, 8'h03, 1, 0};
        vecs[3]  = '{OP_TRB, 8'h12, 8'h80, 8'hE0, 8'h80, 8'h00, 8'hF4, 1, 0};
        vecs[4]  = '{OP_NEG, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h15, 1, 0};
        vecs[5]  = '{OP_NEG, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 8'h0D, 1, 0};
        vecs[6]  = '{OP_AND, 8'hF0, 8'h3C, 8'h08, 8'h30, 8'h00, 8'h00, 1, 0};
        vecs[7]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0};
        vecs[8]  = '{OP_EOR, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'h14, 1, 0};
        vecs[9]  = '{OP_ROR, 8'h01, 8'h00, 8'h01, 8'h80, 8'h00, 8'h15, 1, 0};
        vecs[10] = '{OP_ROL, 8'h80, 8'h00, 8'h01, 8'h01, 8'h00, 8'h19, 1, 0};
        vecs[11] = '{OP_ADC, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 1, 0};
        vecs[12] = '{OP_SBC, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h15, 1, 0};
        vecs[13] = '{OP_RSV, 8'h55, 8'h55, 8'h1F, 8'h00, 8'h00, 8'h1F, 1, 0};
        vecs[14] = '{OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h01, 9, 8};
        vecs[15] = '{OP_MUL, 8'h00, 8'h37, 8'h1C, 8'h00, 8'h00, 8'h1E, 9, 8};
        vecs[16] = '{OP_ASR, 8'h81, 8'h03, 8'h00, 8'hF0, 8'h00, 8'h0C, 4, 3};
        vecs[17] = '{OP_ASR, 8'h81, 8'h00, 8'h0A, 8'h81, 8'h00, 8'h0A, 1, 0};
        vecs[18] = '{OP_LSR, 8'h81, 8'h01, 8'h00, 8'h40, 8'h00, 8'h19, 2, 1};
        vecs[19] = '{OP_LSR, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h02, 8, 7};
        vecs[20] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0};

        reset = 1'b1;
        a     = '0;
        b     = '0;
        op    = '0;
        start = 1'b0;
        st_wr = 1'b0;
        st_in = '0;
        repeat (2) @(negedge clk);
        check("reset r", r, 0);
        check("reset r_hi", r_hi, 0);
        check("reset st", st, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i), -1, 1'b0, '0);
        end

        // Known result in r, then a MUL with a start pulse during RUN that must be ignored.
        v = '{OP_ADD, 8'h11, 8'h22, 8'h00, 8'h33, 8'h00, 8'h00, 1, 0};
        applyStimulus(v, "pre-overlap add", -1, 1'b0, '0);
        v = '{OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h01, 9, 8};
        applyStimulus(v, "mul ignore start", 3, 1'b1, 8'h33);

        // Back-to-back: a new start accepted while in DONE keeps done high.
        @(negedge clk);
        op    = OP_ADD;
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        check("b2b first done", done, 1);
        check("b2b first r", r, 8'h03);
        check("b2b first st", st, 8'h00);
        op = OP_SUB;
        a  = 8'h03;
        b  = 8'h05;
        @(negedge clk);
        check("b2b second done", done, 1);
        check("b2b second r", r, 8'hFE);
        check("b2b second st", st, 8'h15);
        check("b2b second busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        check("b2b back to idle", done, 0);

        // Reset in the middle of a MUL aborts it without a done pulse.
        st_wr = 1'b1;
        st_in = 8'h1F;
        @(negedge clk);
        st_wr = 1'b0;
        op    = OP_MUL;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort r", r, 0);
        check("abort r_hi", r_hi, 0);
        check("abort st", st, 0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done pulse", pulses, 0);
        check("abort r stays zero", r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
